// File: rtl/inst_fetch_unit.sv
// Multi-cycle instruction fetch stage: PC, fetch-address register, and IR behind a req/ready port.
// Optional fetch watchdog is compiled in with `define FETCH_TIMEOUT_EN.
module inst_fetch_unit #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST       = 32'h0000_0013,
    parameter int unsigned     TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_fetch_start,
    input  logic            i_pc_we,
    input  logic [XLEN-1:0] i_pc_next,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_mem_ready,
    output logic [XLEN-1:0] o_inst,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_pc_out,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_busy,
    output logic            o_misalign,
    output logic            o_timeout_err
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
`ifdef FETCH_TIMEOUT_EN
        StErr   = 2'd3,
`endif
        StDone  = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_addr;
    logic [XLEN-1:0] r_inst;
    logic            r_mem_req;
    logic            r_inst_valid;
    logic            r_misalign;
    logic            w_fetch_go;
    logic            w_misalign_hit;
    logic            w_capture;
    logic            w_wait_limit;

    assign w_fetch_go     = (r_state == StIdle) && i_fetch_start && (r_pc[1:0] == 2'b00);
    assign w_misalign_hit = (r_state == StIdle) && i_fetch_start && (r_pc[1:0] != 2'b00);
    assign w_capture      = (r_state == StFetch) && i_mem_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_fetch_go) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                // Ready on the limit edge wins over the timeout.
                if (i_mem_ready) begin
                    w_state_next = StDone;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_wait_limit) begin
                    w_state_next = StErr;
                end
`endif
            end
            StDone: begin
                w_state_next = StIdle;
            end
`ifdef FETCH_TIMEOUT_EN
            StErr: begin
                w_state_next = StErr;
            end
`endif
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_inst       <= NOP_INST;
            r_mem_req    <= 1'b0;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (i_pc_we) begin
                r_pc <= i_pc_next;
            end
            // The fetch address is decoupled from the PC so PC writes never disturb a fetch.
            if (w_fetch_go) begin
                r_fetch_addr <= r_pc;
            end
            if (w_capture) begin
                r_inst <= i_mem_rdata;
            end
            r_mem_req    <= (w_state_next == StFetch);
            r_inst_valid <= (w_state_next == StDone);
            r_misalign   <= w_misalign_hit;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_wait_cnt;
    logic            r_timeout_err;

    assign w_wait_limit = (r_state == StFetch) && !i_mem_ready &&
                          (r_wait_cnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_fetch_go) begin
                r_wait_cnt <= '0;
            end else if ((r_state == StFetch) && !i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_state_next == StErr) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_wait_limit     = 1'b0;
    assign w_unused_timeout = w_wait_limit | (|TIMEOUT_CYCLES);
    assign o_timeout_err    = 1'b0;
`endif

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_fetch_addr;
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_pc_out     = r_pc;
    assign o_pc_plus4   = r_pc + XLEN'(4);
    assign o_busy       = (r_state != StIdle);
    assign o_misalign   = r_misalign;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table plus hand-built corner sequences.
// Expected results are queued as each vector is driven and popped after the clock edge.
module tb_inst_fetch_unit;
    localparam int unsigned XLEN = 32;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_start;
    logic            pc_we;
    logic [XLEN-1:0] pc_next;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic [XLEN-1:0] inst;
    logic            inst_valid;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic            busy;
    logic            misalign;
    logic            timeout_err;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .XLEN          (32),
        .RESET_PC      (32'h0000_0000),
        .NOP_INST      (32'h0000_0013),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fetch_start(fetch_start),
        .i_pc_we      (pc_we),
        .i_pc_next    (pc_next),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ready  (mem_ready),
        .o_inst       (inst),
        .o_inst_valid (inst_valid),
        .o_pc_out     (pc_out),
        .o_pc_plus4   (pc_plus4),
        .o_busy       (busy),
        .o_misalign   (misalign),
        .o_timeout_err(timeout_err)
    );

    typedef struct {
        logic        rst;
        logic        fs;
        logic        we;
        logic [31:0] nxt;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_busy;
        logic        e_mis;
        logic        e_terr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic fs, input logic we,
                                input logic [31:0] nxt, input logic rdy, input logic [31:0] rd,
                                input logic req, input logic [31:0] addr, input logic [31:0] ins,
                                input logic vld, input logic [31:0] pc, input logic bsy,
                                input logic mis, input logic terr);
        vec_t v;
        v.rst = r;       v.fs = fs;       v.we = we;       v.nxt = nxt;
        v.rdy = rdy;     v.rd = rd;       v.e_req = req;   v.e_addr = addr;
        v.e_inst = ins;  v.e_vld = vld;   v.e_pc = pc;     v.e_busy = bsy;
        v.e_mis = mis;   v.e_terr = terr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        rst         = v.rst;
        fetch_start = v.fs;
        pc_we       = v.we;
        pc_next     = v.nxt;
        mem_ready   = v.rdy;
        mem_rdata   = v.rd;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".mem_req"},     32'(mem_req),     32'(e.e_req));
        chk({tag, ".mem_addr"},    mem_addr,         e.e_addr);
        chk({tag, ".inst"},        inst,             e.e_inst);
        chk({tag, ".inst_valid"},  32'(inst_valid),  32'(e.e_vld));
        chk({tag, ".pc_out"},      pc_out,           e.e_pc);
        chk({tag, ".pc_plus4"},    pc_plus4,         e.e_pc + 32'd4);
        chk({tag, ".busy"},        32'(busy),        32'(e.e_busy));
        chk({tag, ".misalign"},    32'(misalign),    32'(e.e_mis));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(e.e_terr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch_start = 1'b0; pc_we = 1'b0;
        pc_next = '0; mem_ready = 1'b0; mem_rdata = '0;

        //                  rst fs we nxt           rdy rd            req addr         inst        vld pc           bsy mis terr
        vecs.push_back(mk(Y, N, N, 32'h0,        N, 32'h0,        N, 32'h0,   32'h13,       N, 32'h0,        N, N, N));
        vecs.push_back(mk(N, Y, N, 32'h0,        N, 32'h0,        Y, 32'h0,   32'h13,       N, 32'h0,        Y, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        Y, 32'h00A00093, N, 32'h0,   32'h00A00093, Y, 32'h0,        Y, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        N, 32'h0,        N, 32'h0,   32'h00A00093, N, 32'h0,        N, N, N));
        vecs.push_back(mk(N, N, Y, 32'h100,      N, 32'h0,        N, 32'h0,   32'h00A00093, N, 32'h100,      N, N, N));
        vecs.push_back(mk(N, Y, N, 32'h0,        N, 32'h0,        Y, 32'h100, 32'h00A00093, N, 32'h100,      Y, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        N, 32'h0,        Y, 32'h100, 32'h00A00093, N, 32'h100,      Y, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        N, 32'h0,        Y, 32'h100, 32'h00A00093, N, 32'h100,      Y, N, N));
        vecs.push_back(mk(N, Y, N, 32'h0,        N, 32'h0,        Y, 32'h100, 32'h00A00093, N, 32'h100,      Y, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        Y, 32'hDEADBEEF, N, 32'h100, 32'hDEADBEEF, Y, 32'h100,      Y, N, N));
        vecs.push_back(mk(N, Y, N, 32'h0,        Y, 32'h11111111, N, 32'h100, 32'hDEADBEEF, N, 32'h100,      N, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        Y, 32'h22222222, N, 32'h100, 32'hDEADBEEF, N, 32'h100,      N, N, N));
        vecs.push_back(mk(N, N, Y, 32'h102,      N, 32'h0,        N, 32'h100, 32'hDEADBEEF, N, 32'h102,      N, N, N));
        vecs.push_back(mk(N, Y, N, 32'h0,        N, 32'h0,        N, 32'h100, 32'hDEADBEEF, N, 32'h102,      N, Y, N));
        vecs.push_back(mk(N, N, N, 32'h0,        N, 32'h0,        N, 32'h100, 32'hDEADBEEF, N, 32'h102,      N, N, N));
        vecs.push_back(mk(N, N, Y, 32'h100,      N, 32'h0,        N, 32'h100, 32'hDEADBEEF, N, 32'h100,      N, N, N));
        vecs.push_back(mk(N, Y, Y, 32'h200,      N, 32'h0,        Y, 32'h100, 32'hDEADBEEF, N, 32'h200,      Y, N, N));
        vecs.push_back(mk(N, N, Y, 32'h300,      N, 32'h0,        Y, 32'h100, 32'hDEADBEEF, N, 32'h300,      Y, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        Y, 32'hCAFEF00D, N, 32'h100, 32'hCAFEF00D, Y, 32'h300,      Y, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        N, 32'h0,        N, 32'h100, 32'hCAFEF00D, N, 32'h300,      N, N, N));
        vecs.push_back(mk(N, Y, N, 32'h0,        N, 32'h0,        Y, 32'h300, 32'hCAFEF00D, N, 32'h300,      Y, N, N));
        vecs.push_back(mk(Y, N, N, 32'h0,        Y, 32'hBAD0BAD0, N, 32'h0,   32'h13,       N, 32'h0,        N, N, N));
        vecs.push_back(mk(N, N, N, 32'h0,        N, 32'h0,        N, 32'h0,   32'h13,       N, 32'h0,        N, N, N));
        vecs.push_back(mk(N, N, Y, 32'hFFFFFFFC, N, 32'h0,        N, 32'h0,   32'h13,       N, 32'hFFFFFFFC, N, N, N));
        vecs.push_back(mk(N, N, Y, 32'h0,        N, 32'h0,        N, 32'h0,   32'h13,       N, 32'h0,        N, N, N));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

`ifdef FETCH_TIMEOUT_EN
        // Sixteen wait cycles with no ready: request drops and the sticky error rises.
        apply(mk(N, Y, N, 32'h0, N, 32'h0, Y, 32'h0, 32'h13, N, 32'h0, Y, N, N), "to_start");
        for (int k = 0; k < 15; k++) begin
            apply(mk(N, N, N, 32'h0, N, 32'h0, Y, 32'h0, 32'h13, N, 32'h0, Y, N, N),
                  $sformatf("to_wait%0d", k));
        end
        apply(mk(N, N, N, 32'h0, N, 32'h0, N, 32'h0, 32'h13, N, 32'h0, Y, N, Y), "to_expire");
        for (int k = 0; k < 2; k++) begin
            apply(mk(N, Y, N, 32'h0, Y, 32'h55555555, N, 32'h0, 32'h13, N, 32'h0, Y, N, Y),
                  $sformatf("to_sticky%0d", k));
        end
        apply(mk(Y, N, N, 32'h0, N, 32'h0, N, 32'h0, 32'h13, N, 32'h0, N, N, N), "to_reset");
        // Ready arriving on the limit edge wins.
        apply(mk(N, Y, N, 32'h0, N, 32'h0, Y, 32'h0, 32'h13, N, 32'h0, Y, N, N), "race_start");
        for (int k = 0; k < 15; k++) begin
            apply(mk(N, N, N, 32'h0, N, 32'h0, Y, 32'h0, 32'h13, N, 32'h0, Y, N, N),
                  $sformatf("race_wait%0d", k));
        end
        apply(mk(N, N, N, 32'h0, Y, 32'h12345678, N, 32'h0, 32'h12345678, Y, 32'h0, Y, N, N),
              "race_capture");
        apply(mk(N, N, N, 32'h0, N, 32'h0, N, 32'h0, 32'h12345678, N, 32'h0, N, N, N), "race_idle");
`else
        // Without the watchdog a fetch waits indefinitely.
        apply(mk(N, Y, N, 32'h0, N, 32'h0, Y, 32'h0, 32'h13, N, 32'h0, Y, N, N), "long_start");
        for (int k = 0; k < 20; k++) begin
            apply(mk(N, N, N, 32'h0, N, 32'h0, Y, 32'h0, 32'h13, N, 32'h0, Y, N, N),
                  $sformatf("long_wait%0d", k));
        end
        apply(mk(N, N, N, 32'h0, Y, 32'h12345678, N, 32'h0, 32'h12345678, Y, 32'h0, Y, N, N),
              "long_capture");
        apply(mk(N, N, N, 32'h0, N, 32'h0, N, 32'h0, 32'h12345678, N, 32'h0, N, N, N), "long_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
